// File: rtl/registro_pipeline.sv
// Elastic pipeline register: STAGES words of WIDTH bits with a valid/ready
// handshake, bubble collapse, a synchronous flush and an occupancy count.
module registro_pipeline #(
    parameter int                 WIDTH       = 8,
    parameter int                 STAGES      = 2,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int                OCC_W       = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] d_q [STAGES];
    logic [WIDTH-1:0] d_d [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] up_valid;
    logic [WIDTH-1:0]  up_data [STAGES];
    logic [OCC_W-1:0]  occ_c;

    // A stage can take a word if it is empty or its own word moves on.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    always_comb begin
        up_valid    = '0;
        up_valid[0] = in_valid;
        up_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            up_valid[k] = v_q[k-1];
            up_data[k]  = d_q[k-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clear) begin
            v_d = '0;
            for (int k = 0; k < STAGES; k++) begin
                d_d[k] = RESET_VALUE;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (up_valid[k] && rdy[k]) begin
                    d_d[k] = up_data[k];
                    v_d[k] = 1'b1;
                end else if (v_q[k] && rdy[k+1]) begin
                    v_d[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        occ_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_c = occ_c + OCC_W'(v_q[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= RESET_VALUE;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = rdy[0] && !clear;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
    assign occupancy = occ_c;

endmodule

// File: tb/tb_registro_pipeline.sv
// Randomised and directed bench for registro_pipeline against a queue model
// where each held word carries its stage position.
module tb_registro_pipeline;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               pos;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           mq[$];
    logic [WIDTH-1:0] lastOut;

    registro_pipeline #(
        .WIDTH(WIDTH), .STAGES(STAGES), .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit modelInReady();
        return !clear && (out_ready || mq.size() < STAGES);
    endfunction

    function automatic bit modelOutValid();
        return mq.size() > 0 && mq[0].pos == STAGES - 1;
    endfunction

    // Words advance one stage per edge unless the word ahead blocks them;
    // a word at the last stage leaves when the consumer is ready.
    task automatic modelStep();
        entry_t nq[$];
        entry_t e;
        int     limit;
        int     np;
        bit     accept;
        accept = in_valid && modelInReady();
        if (clear) begin
            mq.delete();
            lastOut = 8'h00;
            return;
        end
        limit = STAGES;
        foreach (mq[i]) begin
            e = mq[i];
            if (i == 0 && e.pos == STAGES - 1 && out_ready) continue;
            np = (e.pos + 1 < limit - 1) ? e.pos + 1 : limit - 1;
            if (np == STAGES - 1 && e.pos != STAGES - 1) lastOut = e.data;
            e.pos = np;
            limit = np;
            nq.push_back(e);
        end
        if (accept) begin
            e.pos  = 0;
            e.data = in_data;
            nq.push_back(e);
        end
        mq = nq;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(modelInReady()));
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(modelOutValid()));
        checkOutput({tag, ".out_data"},  32'(out_data),  32'(lastOut));
        checkOutput({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                                 input logic clr, input string tag);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(negedge clk);
        compareAll(tag);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < STAGES + 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    endtask

    initial begin
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        lastOut   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle while words are held.
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, "pre_reset");
        applyStimulus(1'b1, 8'h4D, 1'b0, 1'b0, "pre_reset");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "pre_reset");
        #1 reset = 1'b1;
        #1;
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.out_data",  32'(out_data),  32'h00);
        checkOutput("reset.occupancy", 32'(occupancy), 32'd0);
        checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
        mq.delete();
        lastOut = 8'h00;
        reset = 1'b0;

        // Streaming at full rate.
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b0, "stream");
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0, "stream");
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0, "stream");
        #3;
        checkOutput("stream.first_latency", 32'(out_data), 32'h11);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "stream");
        drain();

        // Fill and stall, then release.
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0, "fill");
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0, "fill");
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0, "fill");
        #3;
        checkOutput("fill.in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("fill.occupancy",    32'(occupancy), 32'd3);
        applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, "stall");
        applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0, "stall");
        #3;
        checkOutput("stall.out_data_stable", 32'(out_data), 32'hA1);
        applyStimulus(1'b1, 8'hA4, 1'b1, 1'b0, "release");
        drain();

        // Bubble collapse.
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, "bubble");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "bubble");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "bubble");
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0, "bubble");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, "bubble");
        #3;
        checkOutput("bubble.occupancy", 32'(occupancy), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, "bubble_out");
        #3;
        checkOutput("bubble.no_gap_valid", 32'(out_valid), 32'd1);
        checkOutput("bubble.no_gap_data",  32'(out_data),  32'h66);
        drain();

        // Full with simultaneous push and pop.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, "full_fill");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, "full_pushpop");
            #3;
            checkOutput("full_pushpop.occupancy", 32'(occupancy), 32'd3);
        end
        drain();

        // Clear while traffic is presented.
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, "clear_fill");
        applyStimulus(1'b1, 8'hE2, 1'b0, 1'b0, "clear_fill");
        in_valid = 1'b1;
        in_data  = 8'hE3;
        clear    = 1'b1;
        #1;
        checkOutput("clear.in_ready_low", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 8'hE3, 1'b0, 1'b1, "clear");
        checkOutput("clear.occupancy", 32'(occupancy), 32'd0);
        checkOutput("clear.out_valid", 32'(out_valid), 32'd0);
        checkOutput("clear.out_data",  32'(out_data),  32'h00);

        // Random traffic, including occasional clears.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom),
                          1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 4), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/registro_pipeline.md
# registro_pipeline

Parametrised pipeline register with a valid/ready handshake, replacing the fixed 8-bit capture register wherever data must cross a timing boundary under backpressure. It holds up to STAGES words of WIDTH bits and moves one word per stage per clock. Empty stages are filled so bubbles collapse. It provides a synchronous flush and an occupancy count. It sits between producer and consumer blocks in the datapath, for example between the bus interface and the display and timekeeping logic.

## Interface
- WIDTH, default 8: data word width in bits, at least 1.
- STAGES, default 2: number of register stages, which is also the capacity in words, at least 1.
- RESET_VALUE, default 0: value loaded into every data register on reset or clear.
- clk  input  1  single clock; all registers update on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush, active high.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  pipeline accepts the word this cycle.
- in_data  input  WIDTH  producer word.
- out_valid  output  1  the output stage holds a valid word.
- out_ready  input  1  consumer takes the word this cycle.
- out_data  output  WIDTH  output-stage data register.
- occupancy  output  clog2(STAGES+1)  number of valid words held, from 0 to STAGES.

## Operation
- Stages are numbered 0 (input side) to STAGES-1 (output side). Each stage has a data register d[k] and a flag v[k].
- Per-stage ready is combinational from register state and out_ready: rdy[STAGES] = out_ready, and rdy[k] = !v[k] || rdy[k+1].
- in_ready = rdy[0] && !clear.
- out_valid = v[STAGES-1]; out_data = d[STAGES-1].
- A transfer into stage k occurs when the upstream side is valid and rdy[k] is 1:
  - For k = 0, the upstream side is in_valid and the source is in_data.
  - For k > 0, the upstream side is v[k-1] and the source is d[k-1].
- On a transfer, d[k] takes the upstream value and v[k] is set to 1.
- If stage k is not loaded but its word leaves (rdy[k+1] and v[k]), v[k] is cleared. d[k] holds its value.
- d[k] changes only when a transfer into stage k occurs. No register toggles otherwise.
- Words leave in strict FIFO order. No word is lost or duplicated.
- occupancy = number of set v[k], computed combinationally from the flags.
- clear:
  - All v[k] go to 0 and all d[k] go to RESET_VALUE at the next edge.
  - No input word is accepted in the clear cycle.
  - A word presented at the output in that cycle still counts as consumed if out_valid and out_ready were both 1.
  - clear overrides all transfers.
- reset (asynchronous, immediate):
  - Every v[k] goes to 0 and every d[k] goes to RESET_VALUE.
  - Resulting outputs: out_valid=0, out_data=RESET_VALUE, occupancy=0, and in_ready=!clear. With clear low, in_ready is 1 because all stages are empty.
  - Reset asserted mid-stream discards all held words. The first edge after reset deasserts behaves as if the pipeline had just been emptied.

## Timing
- Latency: a word accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles after in_valid is first sampled.
- Throughput: one word per cycle when out_ready stays at 1.
- Full: when all STAGES flags are set and out_ready=0, in_ready=0 in the same cycle.
- Simultaneous pop and push while full: both occur in the same cycle and occupancy is unchanged. in_ready follows out_ready in the same cycle.
- in_ready has a combinational path from out_ready through STAGES logic levels. There is no combinational path from in_valid or in_data to any output.
- A stalled word holds out_data stable for as long as out_ready=0.

## Test plan
1. Reset (WIDTH=8, STAGES=3, RESET_VALUE=8'h00): assert reset mid-cycle -> out_valid=0, out_data=8'h00, occupancy=0, in_ready=1 immediately, without a clock edge.
2. Streaming: out_ready=1, push 8'h11, 8'h22, 8'h33 on consecutive cycles -> out_data shows 11, 22, 33 on consecutive cycles, with the first valid exactly 2 edges after its accept edge. occupancy never exceeds 3.
3. Fill and stall: out_ready=0, push 8'hA1..8'hA4 -> in_ready drops after the 3rd accept, so A4 is held off. occupancy=3. out_data=A1 stays stable. Then out_ready=1 -> A1, A2, A3, A4 emerge in order.
4. Bubble collapse: push 8'h55, idle 2 cycles with out_ready=0, then push 8'h66 -> 55 and 66 end up in stages 2 and 1, occupancy=2, with no gap at the output once out_ready rises.
5. Full with simultaneous push and pop: pipeline full, in_valid=1 and out_ready=1 for 4 cycles -> one word in and one out per cycle, occupancy held at 3, order preserved.
6. Clear with traffic: with occupancy=2 and in_valid=1, assert clear for 1 cycle -> in_ready=0 during clear, and after the edge occupancy=0, out_valid=0, out_data=8'h00. The presented word is not accepted.
